// File: rtl/sync_porch_gen.sv
// VGA sync generator: turns active-video flags into porched, active-low HSYNC/VSYNC
// with a 2-cycle aligned colour/count pipeline. Optional check logic: SYNC_TIMING_CHECK_EN.
module sync_porch_gen #(
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int VIDEO_WIDTH   = 3,
  parameter int CNT_WIDTH     = 10
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_h_active,
  input  logic                   i_v_active,
  input  logic [9:0]             i_col_num,
  input  logic [9:0]             i_row_num,
  input  logic [VIDEO_WIDTH-1:0] i_red,
  input  logic [VIDEO_WIDTH-1:0] i_grn,
  input  logic [VIDEO_WIDTH-1:0] i_blu,
  output logic                   o_h_sync,
  output logic                   o_v_sync,
  output logic [VIDEO_WIDTH-1:0] o_red,
  output logic [VIDEO_WIDTH-1:0] o_grn,
  output logic [VIDEO_WIDTH-1:0] o_blu,
  output logic [9:0]             o_col_num,
  output logic [9:0]             o_row_num,
  output logic                   o_timing_err
);

  // state  | meaning
  // WAIT   | after reset, no edge seen yet; sync inactive
  // ACTIVE | inside visible region
  // FRONT  | front porch, counting cycles (H) or lines (V)
  // SYNC   | sync pulse low, counting cycles (H) or lines (V)
  // BACK   | back porch, waiting for the next active rise
  typedef enum logic [2:0] {ST_WAIT, ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] H_FP_LAST = CNT_WIDTH'(H_FRONT_PORCH - 1);
  localparam logic [CNT_WIDTH-1:0] H_SW_LAST = CNT_WIDTH'(H_SYNC_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] V_FP_LAST = CNT_WIDTH'(V_FRONT_PORCH - 1);
  localparam logic [CNT_WIDTH-1:0] V_SW_LAST = CNT_WIDTH'(V_SYNC_WIDTH - 1);

  state_t r_h_state, w_h_state_nxt, r_v_state, w_v_state_nxt;
  logic [CNT_WIDTH-1:0] r_h_cnt, w_h_cnt_nxt, r_v_cnt, w_v_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_h_cnt_inc, w_v_cnt_inc;

  logic                   r_h_d1, r_v_d1;
  logic [VIDEO_WIDTH-1:0] r_red_d1, r_grn_d1, r_blu_d1;
  logic [9:0]             r_col_d1, r_row_d1;

  logic                   r_h_sync, r_v_sync;
  logic [VIDEO_WIDTH-1:0] r_red, r_grn, r_blu;
  logic [9:0]             r_col, r_row;

  logic w_h_fall, w_h_rise, w_v_fall, w_v_rise;

  // First pipeline stage doubles as the edge-detect history.
  assign w_h_fall = r_h_d1 & ~i_h_active;
  assign w_h_rise = ~r_h_d1 & i_h_active;
  assign w_v_fall = r_v_d1 & ~i_v_active;
  assign w_v_rise = ~r_v_d1 & i_v_active;

  assign w_h_cnt_inc = (r_h_cnt == CNT_MAX) ? r_h_cnt : r_h_cnt + CNT_WIDTH'(1);
  assign w_v_cnt_inc = (r_v_cnt == CNT_MAX) ? r_v_cnt : r_v_cnt + CNT_WIDTH'(1);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_h_state <= ST_WAIT;
      r_v_state <= ST_WAIT;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      r_h_state <= w_h_state_nxt;
      r_v_state <= w_v_state_nxt;
      r_h_cnt   <= w_h_cnt_nxt;
      r_v_cnt   <= w_v_cnt_nxt;
    end
  end

  always_comb begin
    w_h_state_nxt = r_h_state;
    w_h_cnt_nxt   = r_h_cnt;
    case (r_h_state)
      ST_WAIT: begin
        if (w_h_rise) begin
          w_h_state_nxt = ST_ACTIVE;
        end else if (w_h_fall) begin
          w_h_state_nxt = ST_FRONT;
          w_h_cnt_nxt   = '0;
        end
      end
      ST_ACTIVE: begin
        if (w_h_fall) begin
          w_h_state_nxt = ST_FRONT;
          w_h_cnt_nxt   = '0;
        end
      end
      ST_FRONT: begin
        if (w_h_rise) begin
          w_h_state_nxt = ST_ACTIVE;
        end else if (r_h_cnt == H_FP_LAST) begin
          w_h_state_nxt = ST_SYNC;
          w_h_cnt_nxt   = '0;
        end else begin
          w_h_cnt_nxt = w_h_cnt_inc;
        end
      end
      ST_SYNC: begin
        if (w_h_rise) begin
          w_h_state_nxt = ST_ACTIVE;
        end else if (r_h_cnt == H_SW_LAST) begin
          w_h_state_nxt = ST_BACK;
        end else begin
          w_h_cnt_nxt = w_h_cnt_inc;
        end
      end
      ST_BACK: if (w_h_rise) w_h_state_nxt = ST_ACTIVE;
      default: w_h_state_nxt = ST_WAIT;
    endcase
  end

  // Vertical machine only advances on line ends (h_fall).
  always_comb begin
    w_v_state_nxt = r_v_state;
    w_v_cnt_nxt   = r_v_cnt;
    case (r_v_state)
      ST_WAIT: begin
        if (w_v_rise) begin
          w_v_state_nxt = ST_ACTIVE;
        end else if (w_v_fall) begin
          w_v_state_nxt = ST_FRONT;
          w_v_cnt_nxt   = '0;
        end
      end
      ST_ACTIVE: begin
        if (w_v_fall) begin
          w_v_state_nxt = ST_FRONT;
          w_v_cnt_nxt   = '0;
        end
      end
      ST_FRONT: begin
        if (w_v_rise) begin
          w_v_state_nxt = ST_ACTIVE;
        end else if (w_h_fall) begin
          if (r_v_cnt == V_FP_LAST) begin
            w_v_state_nxt = ST_SYNC;
            w_v_cnt_nxt   = '0;
          end else begin
            w_v_cnt_nxt = w_v_cnt_inc;
          end
        end
      end
      ST_SYNC: begin
        if (w_v_rise) begin
          w_v_state_nxt = ST_ACTIVE;
        end else if (w_h_fall) begin
          if (r_v_cnt == V_SW_LAST) w_v_state_nxt = ST_BACK;
          else                      w_v_cnt_nxt   = w_v_cnt_inc;
        end
      end
      ST_BACK: if (w_v_rise) w_v_state_nxt = ST_ACTIVE;
      default: w_v_state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_h_d1   <= 1'b0;
      r_v_d1   <= 1'b0;
      r_red_d1 <= '0;
      r_grn_d1 <= '0;
      r_blu_d1 <= '0;
      r_col_d1 <= '0;
      r_row_d1 <= '0;
      r_h_sync <= 1'b1;
      r_v_sync <= 1'b1;
      r_red    <= '0;
      r_grn    <= '0;
      r_blu    <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else begin
      r_h_d1   <= i_h_active;
      r_v_d1   <= i_v_active;
      r_red_d1 <= i_red;
      r_grn_d1 <= i_grn;
      r_blu_d1 <= i_blu;
      r_col_d1 <= i_col_num;
      r_row_d1 <= i_row_num;
      // State register already lags the input by one cycle, so one more stage aligns sync.
      r_h_sync <= (r_h_state != ST_SYNC);
      r_v_sync <= (r_v_state != ST_SYNC);
      r_red    <= (r_h_d1 & r_v_d1) ? r_red_d1 : '0;
      r_grn    <= (r_h_d1 & r_v_d1) ? r_grn_d1 : '0;
      r_blu    <= (r_h_d1 & r_v_d1) ? r_blu_d1 : '0;
      r_col    <= r_col_d1;
      r_row    <= r_row_d1;
    end
  end

  assign o_h_sync  = r_h_sync;
  assign o_v_sync  = r_v_sync;
  assign o_red     = r_red;
  assign o_grn     = r_grn;
  assign o_blu     = r_blu;
  assign o_col_num = r_col;
  assign o_row_num = r_row;

`ifdef SYNC_TIMING_CHECK_EN
  logic w_h_bad, w_v_bad, r_timing_err;

  assign w_h_bad = ((r_h_state == ST_FRONT) || (r_h_state == ST_SYNC)) &&
                   (w_h_rise || (r_h_cnt == CNT_MAX));
  assign w_v_bad = ((r_v_state == ST_FRONT) || (r_v_state == ST_SYNC)) &&
                   (w_v_rise || (r_v_cnt == CNT_MAX));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) r_timing_err <= 1'b0;
    else         r_timing_err <= r_timing_err | w_h_bad | w_v_bad;
  end

  assign o_timing_err = r_timing_err;
`else
  assign o_timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_sync_porch_gen.sv
// Scoreboard bench for sync_porch_gen: two instances (default porches and a short 4/8 H porch)
// share one stimulus stream; an event-based reference model predicts every output cycle.
module tb_sync_porch_gen;
  localparam int VFP = 10, VSW = 2;
  localparam int FP0 = 16, SW0 = 96, FP1 = 4, SW1 = 8;
`ifdef SYNC_TIMING_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    logic [9:0] col;
    logic [9:0] row;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_in = 1'b1, h_in = 1'b0, v_in = 1'b0;
  logic [9:0] col_in = '0, row_in = '0;
  logic [2:0] r_in = '0, g_in = '0, b_in = '0;

  logic o0_h, o0_v, o0_err, o1_h, o1_v, o1_err;
  logic [2:0] o0_r, o0_g, o0_b, o1_r, o1_g, o1_b;
  logic [9:0] o0_col, o0_row, o1_col, o1_row;
  exp_t got0, got1;

  always #5 clk = ~clk;

  sync_porch_gen u_dut0 (
    .i_Clk(clk), .i_Reset(rst_in), .i_h_active(h_in), .i_v_active(v_in),
    .i_col_num(col_in), .i_row_num(row_in), .i_red(r_in), .i_grn(g_in), .i_blu(b_in),
    .o_h_sync(o0_h), .o_v_sync(o0_v), .o_red(o0_r), .o_grn(o0_g), .o_blu(o0_b),
    .o_col_num(o0_col), .o_row_num(o0_row), .o_timing_err(o0_err));

  sync_porch_gen #(.H_FRONT_PORCH(FP1), .H_SYNC_WIDTH(SW1)) u_dut1 (
    .i_Clk(clk), .i_Reset(rst_in), .i_h_active(h_in), .i_v_active(v_in),
    .i_col_num(col_in), .i_row_num(row_in), .i_red(r_in), .i_grn(g_in), .i_blu(b_in),
    .o_h_sync(o1_h), .o_v_sync(o1_v), .o_red(o1_r), .o_grn(o1_g), .o_blu(o1_b),
    .o_col_num(o1_col), .o_row_num(o1_row), .o_timing_err(o1_err));

  assign got0 = {o0_h, o0_v, o0_r, o0_g, o0_b, o0_col, o0_row, o0_err};
  assign got1 = {o1_h, o1_v, o1_r, o1_g, o1_b, o1_col, o1_row, o1_err};

  exp_t q0[$], q1[$];
  int n_tests = 0, n_fail = 0, mon_t = 0;

  // Reference model state: index of the latest fall while the flag has stayed low,
  // number of line ends since the frame-active fall, sticky error per instance.
  int   cyc = 0, h_fall_at = 0, n_hf = 0;
  bit   h_run = 0, v_run = 0, p_h = 0, p_v = 0, p_rst = 1;
  bit   err_m[2] = '{0, 0};
  exp_t prev_cur[2];
  exp_t rst_exp = {1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 10'd0, 10'd0, 1'b0};

  task automatic check(input int inst, input exp_t e, input exp_t g);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL out_dut%0d t=%0d got hs=%b vs=%b rgb=%0d/%0d/%0d col=%0d row=%0d err=%b exp hs=%b vs=%b rgb=%0d/%0d/%0d col=%0d row=%0d err=%b",
               inst, mon_t, g.hs, g.vs, g.r, g.g, g.b, g.col, g.row, g.err,
               e.hs, e.vs, e.r, e.g, e.b, e.col, e.row, e.err);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    mon_t++;
    if (q0.size() > 0) check(0, q0.pop_front(), got0);
    if (q1.size() > 0) check(1, q1.pop_front(), got1);
  end

  task automatic drive(input bit h, input bit v, input logic [9:0] col, input logic [9:0] row,
                       input logic [2:0] r, input logic [2:0] g, input logic [2:0] b, input bit rst);
    bit ph, pv, hf, hr, vf, vr;
    int fp, sw, dh;
    exp_t cur, e;
    @(negedge clk);
    h_in = h; v_in = v; col_in = col; row_in = row; r_in = r; g_in = g; b_in = b; rst_in = rst;
    ph = !p_rst && p_h;
    pv = !p_rst && p_v;
    hf = ph && !h; hr = !ph && h; vf = pv && !v; vr = !pv && v;
    if (rst) begin
      h_run = 0; v_run = 0; err_m[0] = 0; err_m[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        fp = (i == 0) ? FP0 : FP1;
        sw = (i == 0) ? SW0 : SW1;
        if ((hr && h_run && (cyc - h_fall_at) <= fp + sw) || (vr && v_run && n_hf < VFP + VSW))
          err_m[i] = 1;
      end
      if (vr) v_run = 0;
      if (vf) begin v_run = 1; n_hf = 0; end
      else if (v_run && hf) n_hf++;
      if (hr) h_run = 0;
      if (hf) begin h_run = 1; h_fall_at = cyc; end
    end
    for (int i = 0; i < 2; i++) begin
      fp = (i == 0) ? FP0 : FP1;
      sw = (i == 0) ? SW0 : SW1;
      dh = cyc - h_fall_at;
      cur.hs  = !(h_run && dh >= fp && dh <= fp + sw - 1);
      cur.vs  = !(v_run && n_hf >= VFP && n_hf <= VFP + VSW - 1);
      cur.r   = (h && v) ? r : 3'd0;
      cur.g   = (h && v) ? g : 3'd0;
      cur.b   = (h && v) ? b : 3'd0;
      cur.col = col;
      cur.row = row;
      cur.err = 1'b0;
      if (rst || p_rst) e = rst_exp;
      else begin
        e = prev_cur[i];
        e.err = ERR_EN ? err_m[i] : 1'b0;
      end
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      prev_cur[i] = cur;
    end
    p_h = h; p_v = v; p_rst = rst;
    cyc++;
  endtask

  task automatic raster(input int row0, input int nrows, input bit rnd, input int rst_at);
    int row;
    logic [2:0] r, g, b;
    for (int i = 0; i < nrows; i++) begin
      row = (row0 + i) % 525;
      for (int c = 0; c < 800; c++) begin
        r = rnd ? 3'($urandom) : 3'd7;
        g = rnd ? 3'($urandom) : 3'd7;
        b = rnd ? 3'($urandom) : 3'd7;
        drive(c < 640, row < 480, 10'(c), 10'(row), r, g, b, (i * 800 + c) == rst_at);
      end
    end
  endtask

  task automatic hold(input bit h, input bit v, input int n, input bit rnd_rst);
    for (int k = 0; k < n; k++)
      drive(h, v, 10'($urandom), 10'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            rnd_rst && ($urandom_range(0, 299) == 0));
  endtask

  task automatic reset_toggle(input int n);
    for (int k = 0; k < n; k++)
      drive(1'($urandom), 1'($urandom), 10'($urandom), 10'($urandom),
            3'($urandom), 3'($urandom), 3'($urandom), 1'b1);
  endtask

  initial begin
    bit v;
    reset_toggle(5);
    raster(476, 20, 1'b0, -1);       // frame end: v falls at row 480 with colour fixed at 7
    raster(523, 4, 1'b1, -1);        // wrap into the next frame
    raster(2, 3, 1'b1, 700);         // one-cycle reset inside HSYNC
    hold(1, 1, 30, 0);               // early re-rise 6 cycles after the fall
    hold(0, 1, 6, 0);
    hold(1, 1, 30, 0);
    hold(0, 1, 200, 0);
    reset_toggle(1);
    v = 1'b1;
    for (int s = 0; s < 70; s++) begin
      if ($urandom_range(0, 3) == 0) v = !v;
      hold(1, v, $urandom_range(1, 40), 1);
      hold(0, v, $urandom_range(1, 130), 1);
    end
    reset_toggle(5);
    hold(0, 0, 3, 0);
    @(posedge clk);
    #2;
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain got q0=%0d q1=%0d exp 0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_porch_gen.md
Name: sync_porch_gen

Overview:
- Downstream of the raster counter stage, which supplies column/row counts and active-high "active video" flags (high inside the 640x480 visible area).
- Converts those flags into VGA-compliant active-low HSYNC/VSYNC pulses with front porch, sync width and back porch.
- Delays the pixel colour stream so colour and sync leave the block aligned, and forces colour to 0 outside the visible area.
- Output drives the FPGA VGA pins directly.

Parameters:
- H_FRONT_PORCH, 16, cycles from end of line active to HSYNC assertion
- H_SYNC_WIDTH, 96, HSYNC low duration in cycles
- V_FRONT_PORCH, 10, lines from end of frame active to VSYNC assertion
- V_SYNC_WIDTH, 2, VSYNC low duration in lines
- VIDEO_WIDTH, 3, bits per colour channel
- CNT_WIDTH, 10, width of internal porch/line counters

Ports:
- i_Clk  in  1  pixel clock (25.175 MHz nominal)
- i_Reset  in  1  synchronous, active-high reset
- i_h_active  in  1  high while column is in the active region
- i_v_active  in  1  high while row is in the active region
- i_col_num  in  10  column count, pipelined through only
- i_row_num  in  10  row count, pipelined through only
- i_red, i_grn, i_blu  in  VIDEO_WIDTH each  pixel colour for the current col/row
- o_h_sync  out  1  HSYNC, active low
- o_v_sync  out  1  VSYNC, active low
- o_red, o_grn, o_blu  out  VIDEO_WIDTH each  delayed, blanked colour
- o_col_num, o_row_num  out  10 each  counts delayed to match the outputs
- o_timing_err  out  1  sticky malformed-timing flag (see Optional Feature)

Behaviour:
- Reset (synchronous, takes priority over all else):
  - o_h_sync = 1, o_v_sync = 1; colour outputs 0; o_col_num/o_row_num 0; o_timing_err 0.
  - Both FSMs go to WAIT; edge-detect registers cleared to 0.
- Fixed pipeline latency of 2 cycles, input to output, for colour, counts and sync.
- Edge detect on the registered previous value:
  - h_fall = prev_h & ~i_h_active; h_rise = ~prev_h & i_h_active.
  - v_fall and v_rise are formed the same way from i_v_active.
- Horizontal FSM, states WAIT, ACTIVE, FRONT, SYNC, BACK:
  - WAIT: HSYNC inactive; h_rise -> ACTIVE; h_fall -> FRONT.
  - ACTIVE: h_fall -> FRONT, porch counter cleared.
  - FRONT: counts H_FRONT_PORCH cycles, then -> SYNC.
  - SYNC: HSYNC low for exactly H_SYNC_WIDTH cycles, then -> BACK.
  - BACK: HSYNC high; h_rise -> ACTIVE.
  - Net timing: i_h_active first 0 at input cycle N -> o_h_sync low for output cycles N+2+H_FRONT_PORCH through N+1+H_FRONT_PORCH+H_SYNC_WIDTH inclusive.
- Vertical FSM, same states, advanced by line events (h_fall):
  - ACTIVE: v_fall -> FRONT, line counter cleared.
  - FRONT: after V_FRONT_PORCH h_fall events -> SYNC; o_v_sync goes low in the output cycle aligned with that h_fall (+2 latency).
  - SYNC: held low for V_SYNC_WIDTH h_fall events, then -> BACK.
  - BACK: v_rise -> ACTIVE.
- Simultaneous v_fall and h_rise in one cycle is normal at frame end: both are processed, and neither FSM blocks the other.
- Early rise: h_rise in FRONT/SYNC (or v_rise in V FRONT/SYNC):
  - The affected FSM goes to ACTIVE immediately.
  - Its sync output returns high on the next pipeline output.
  - o_timing_err is set (when enabled).
- Blanking: colour outputs = delayed colour only when both delayed active flags are 1; otherwise 0.
- Counters saturate at all-ones and never wrap. A saturated counter in FRONT/SYNC counts as malformed timing.
- Reset mid-pulse: sync outputs go high the next cycle; no pulse is resumed after reset release.

Optional Feature:
- Macro SYNC_TIMING_CHECK_EN.
- Defined:
  - o_timing_err is a sticky flag, set on an early rise or counter saturation.
  - Cleared only by i_Reset.
- Undefined:
  - Check logic is not compiled in; o_timing_err is tied to 0.
  - Early-rise recovery to ACTIVE still applies.

Test Plan:
- Default params, upstream-style counts (800 cols x 525 rows):
  - h_active falls at cycle 640 -> o_h_sync low for output cycles 658..753, high elsewhere.
- Frame end, v_active falls at row 480:
  - o_v_sync low for exactly 2 lines, starting at the 10th subsequent h_fall.
  - o_h_sync keeps pulsing during the vertical pulse.
- Colour fixed at 3'b111:
  - o_red/o_grn/o_blu = 7 only on delayed-active cycles; 0 during all porches and sync.
  - Counts lag inputs by exactly 2 cycles.
- H_FRONT_PORCH=4, H_SYNC_WIDTH=8; h_active re-rises 6 cycles after falling:
  - o_h_sync returns high early.
  - o_timing_err = 1 with the macro defined, 0 without.
- Assert i_Reset for 1 cycle mid-HSYNC:
  - Next cycle: o_h_sync = 1, outputs 0, FSMs in WAIT.
  - The following h_fall produces a correct full pulse.
- Reset held 5 cycles with toggling inputs:
  - All outputs stay at reset values throughout.
